// File: rtl/regsel_encoder_serializer_if.sv
// Handshake bundle between a bitmap producer, the encoder/serializer and the
// address consumer. The slave modport is the serializer's view.
interface regsel_encoder_serializer_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_bits;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_address;
    logic             out_last;
    logic             done;
    logic [WIDTH-1:0] pending;

    modport slave (
        input  load_valid, load_bits, out_ready,
        output load_ready, out_valid, out_address, out_last, done, pending
    );

    modport master (
        output load_valid, load_bits, out_ready,
        input  load_ready, out_valid, out_address, out_last, done, pending
    );
endinterface

// File: rtl/regsel_encoder_serializer.sv
// Drains a multi-hot register-select bitmap as a stream of register addresses,
// lowest index first, one address per accepted handshake.
module regsel_encoder_serializer #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic clk,
    input  logic reset,
    regsel_encoder_serializer_if.slave bus
);
    typedef enum logic {IDLE, DRAIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] pending_q;
    logic             done_q;
    logic [AW-1:0]    low_idx;
    logic             single;

    // Scanning downwards lets the lowest set bit be the last one written.
    function automatic logic [AW-1:0] lowest_set(input logic [WIDTH-1:0] v);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = AW'(i);
        end
        return idx;
    endfunction

    assign low_idx = lowest_set(pending_q);
    assign single  = ((pending_q & (pending_q - WIDTH'(1))) == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load_valid) begin
                        pending_q <= bus.load_bits;
                        if (bus.load_bits != '0) state  <= DRAIN;
                        else                     done_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        pending_q[low_idx] <= 1'b0;
                        if (single) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address and last flag are forced low outside DRAIN so idle outputs are clean.
    assign bus.load_ready  = (state == IDLE);
    assign bus.out_valid   = (state == DRAIN);
    assign bus.out_address = (state == DRAIN) ? low_idx : '0;
    assign bus.out_last    = (state == DRAIN) && single;
    assign bus.done        = done_q;
    assign bus.pending     = pending_q;
endmodule

// File: tb/tb_regsel_encoder_serializer.sv
// Directed bench for regsel_encoder_serializer: drives on the falling edge,
// samples on the falling edge, so every check sits half a cycle from posedge.
module tb_regsel_encoder_serializer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    regsel_encoder_serializer_if #(.WIDTH(32), .AW(5)) bus ();

    regsel_encoder_serializer #(.WIDTH(32), .AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a bitmap for exactly one rising edge; returns just after it.
    task automatic do_load(input logic [31:0] bits);
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_bits  = bits;
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL rst_load_ready: got %0b expected 1", bus.load_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b expected 0", bus.out_valid); end
        n_checks++; if (bus.out_address !== 5'd0) begin n_fail++; $display("FAIL rst_out_address: got %0d expected 0", bus.out_address); end
        n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %0b expected 0", bus.out_last); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b expected 0", bus.done); end
        n_checks++; if (bus.pending !== 32'h0) begin n_fail++; $display("FAIL rst_pending: got %0h expected 0", bus.pending); end
        reset = 1'b0;
    endtask

    task automatic test_two_bits();
        bus.out_ready = 1'b1;
        do_load(32'h0000_8001);
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL two_valid0: got %0b expected 1", bus.out_valid); end
        n_checks++; if (bus.out_address !== 5'd0) begin n_fail++; $display("FAIL two_addr0: got %0d expected 0", bus.out_address); end
        n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL two_last0: got %0b expected 0", bus.out_last); end
        n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL two_load_ready0: got %0b expected 0", bus.load_ready); end
        @(negedge clk);
        n_checks++; if (bus.out_address !== 5'd15) begin n_fail++; $display("FAIL two_addr1: got %0d expected 15", bus.out_address); end
        n_checks++; if (bus.out_last !== 1'b1) begin n_fail++; $display("FAIL two_last1: got %0b expected 1", bus.out_last); end
        n_checks++; if (bus.pending !== 32'h0000_8000) begin n_fail++; $display("FAIL two_pending1: got %0h expected 8000", bus.pending); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL two_done: got %0b expected 1", bus.done); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL two_valid_end: got %0b expected 0", bus.out_valid); end
        n_checks++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL two_load_ready_end: got %0b expected 1", bus.load_ready); end
        n_checks++; if (bus.out_address !== 5'd0) begin n_fail++; $display("FAIL two_addr_idle: got %0d expected 0", bus.out_address); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL two_done_pulse: got %0b expected 0", bus.done); end
    endtask

    task automatic test_all_ones();
        logic [31:0] exp_pend;
        bus.out_ready = 1'b1;
        do_load(32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            exp_pend = 32'hFFFF_FFFF << i;
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ones_valid[%0d]: got %0b expected 1", i, bus.out_valid); end
            n_checks++; if (bus.out_address !== 5'(i)) begin n_fail++; $display("FAIL ones_addr[%0d]: got %0d expected %0d", i, bus.out_address, i); end
            n_checks++; if (bus.out_last !== (i == 31)) begin n_fail++; $display("FAIL ones_last[%0d]: got %0b expected %0b", i, bus.out_last, (i == 31)); end
            n_checks++; if (bus.pending !== exp_pend) begin n_fail++; $display("FAIL ones_pending[%0d]: got %0h expected %0h", i, bus.pending, exp_pend); end
        end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ones_done: got %0b expected 1", bus.done); end
        n_checks++; if (bus.pending !== 32'h0) begin n_fail++; $display("FAIL ones_pending_end: got %0h expected 0", bus.pending); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ones_valid_end: got %0b expected 0", bus.out_valid); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        do_load(32'h8000_0004);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %0b expected 1", i, bus.out_valid); end
            n_checks++; if (bus.out_address !== 5'd2) begin n_fail++; $display("FAIL stall_addr[%0d]: got %0d expected 2", i, bus.out_address); end
            n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL stall_last[%0d]: got %0b expected 0", i, bus.out_last); end
            n_checks++; if (bus.pending !== 32'h8000_0004) begin n_fail++; $display("FAIL stall_pending[%0d]: got %0h expected 80000004", i, bus.pending); end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.out_address !== 5'd31) begin n_fail++; $display("FAIL stall_addr31: got %0d expected 31", bus.out_address); end
        n_checks++; if (bus.out_last !== 1'b1) begin n_fail++; $display("FAIL stall_last31: got %0b expected 1", bus.out_last); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %0b expected 1", bus.done); end
        @(negedge clk);
    endtask

    task automatic test_empty();
        bus.out_ready = 1'b1;
        do_load(32'h0);
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid: got %0b expected 0", bus.out_valid); end
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL empty_done: got %0b expected 1", bus.done); end
        n_checks++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL empty_load_ready: got %0b expected 1", bus.load_ready); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL empty_done_pulse: got %0b expected 0", bus.done); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid_after: got %0b expected 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_drain();
        bus.out_ready = 1'b1;
        do_load(32'h0000_00F0);
        @(negedge clk);
        n_checks++; if (bus.out_address !== 5'd4) begin n_fail++; $display("FAIL mid_addr4: got %0d expected 4", bus.out_address); end
        @(negedge clk);
        n_checks++; if (bus.out_address !== 5'd5) begin n_fail++; $display("FAIL mid_addr5: got %0d expected 5", bus.out_address); end
        reset = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0b expected 0", bus.out_valid); end
        n_checks++; if (bus.pending !== 32'h0) begin n_fail++; $display("FAIL mid_pending: got %0h expected 0", bus.pending); end
        n_checks++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL mid_load_ready: got %0b expected 1", bus.load_ready); end
        n_checks++; if (bus.out_address !== 5'd0) begin n_fail++; $display("FAIL mid_addr_rst: got %0d expected 0", bus.out_address); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_output[%0d]: got %0b expected 0", i, bus.out_valid); end
            n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done[%0d]: got %0b expected 0", i, bus.done); end
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        do_load(32'h0000_0300);
        @(negedge clk);
        n_checks++; if (bus.out_address !== 5'd8) begin n_fail++; $display("FAIL b2b_addr8: got %0d expected 8", bus.out_address); end
        n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_load_ready: got %0b expected 0", bus.load_ready); end
        bus.load_valid = 1'b1;
        bus.load_bits  = 32'h0000_0001;
        @(negedge clk);
        n_checks++; if (bus.out_address !== 5'd9) begin n_fail++; $display("FAIL b2b_addr9: got %0d expected 9", bus.out_address); end
        n_checks++; if (bus.out_last !== 1'b1) begin n_fail++; $display("FAIL b2b_last9: got %0b expected 1", bus.out_last); end
        n_checks++; if (bus.pending !== 32'h0000_0200) begin n_fail++; $display("FAIL b2b_no_merge: got %0h expected 200", bus.pending); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %0b expected 1", bus.done); end
        n_checks++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_load_ready_done: got %0b expected 1", bus.load_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_done: got %0b expected 0", bus.out_valid); end
        @(negedge clk);
        bus.load_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_new: got %0b expected 1", bus.out_valid); end
        n_checks++; if (bus.out_address !== 5'd0) begin n_fail++; $display("FAIL b2b_addr0: got %0d expected 0", bus.out_address); end
        n_checks++; if (bus.out_last !== 1'b1) begin n_fail++; $display("FAIL b2b_last0: got %0b expected 1", bus.out_last); end
        n_checks++; if (bus.pending !== 32'h0000_0001) begin n_fail++; $display("FAIL b2b_pending_new: got %0h expected 1", bus.pending); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_new: got %0b expected 1", bus.done); end
        @(negedge clk);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_bits  = 32'h0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_two_bits();
        test_all_ones();
        test_stall();
        test_empty();
        test_reset_mid_drain();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regsel_encoder_serializer.md
Name: regsel_encoder_serializer

Overview:
- Inverse partner of the register-file write-select decoder.
- Accepts a 32-bit multi-hot register-select bitmap and serializes it into a stream of 5-bit register addresses, lowest index first.
- Uses a valid/ready handshake on both sides.
- Used to drain pending register writes or scan a dirty-register mask one address per cycle into the regfile's decoder-addressed write port.

Parameters:
- WIDTH, 32, bitmap width; must equal 2**AW.
- AW, 5, address width of out_address.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  load_bits is valid.
- load_ready  output  1  block can accept a new bitmap.
- load_bits  input  WIDTH  multi-hot select bitmap.
- out_valid  output  1  out_address is valid.
- out_ready  input  1  consumer accepts out_address.
- out_address  output  AW  index of lowest set bit still pending.
- out_last  output  1  out_address is the final pending bit (valid only with out_valid).
- done  output  1  one-cycle pulse after the final address is accepted.
- pending  output  WIDTH  registered bitmap of bits not yet emitted.

Behaviour:
- Reset (async, immediate):
  - State IDLE, pending=0.
  - load_ready=1, out_valid=0, out_address=0, out_last=0, done=0.
  - Reset mid-drain discards all remaining bits; no further outputs.
- State IDLE:
  - load_ready=1, out_valid=0.
  - On posedge with load_valid=1: pending<=load_bits.
  - Next state is DRAIN if load_bits!=0. If load_bits==0, stay IDLE and pulse done next cycle (empty load completes immediately).
- State DRAIN:
  - load_ready=0; load_valid is ignored and the bitmap is not merged.
  - out_valid=1.
  - out_address = index of lowest set bit of pending. This is combinational from the registered pending, so no added latency.
  - out_last=1 iff exactly one bit of pending is set.
- Handshake:
  - Transfer occurs on posedge where out_valid & out_ready.
  - On transfer: clear pending[out_address].
  - If out_last, go to IDLE and assert done for the next cycle only.
  - While out_valid=1 and out_ready=0: out_address, out_last and pending hold stable.
- Latency and throughput:
  - Bitmap accepted at edge N gives first out_valid in cycle N+1.
  - With out_ready held high, k set bits emit on k consecutive cycles.
  - done is high in cycle N+k+1; load_ready is high again in the same cycle.
- Back-to-back loads: a new load can be accepted in the same cycle done is high (IDLE state), giving no bubble beyond the done cycle.
- Ordering: strictly ascending index. Bit 0 maps to address 0; bit 31 maps to address 31. No wrap-around; scanning never restarts within a bitmap.
- Width rule: out_address is exactly AW bits. Decoding out_address with the 1-to-32 decoder (enable=1) must equal the lowest set bit of pending.
- out_address defaults to 0 whenever out_valid=0.
- Implementation:
  - Two-state FSM plus a WIDTH-bit register.
  - Lowest-set-bit priority encoder and a single-bit detector (pending & (pending-1))==0.
  - No latches; all outputs are derived from registered state.

Test Plan:
- Reset, then load 32'h0000_8001 with out_ready=1 -> out_address 0 (out_last=0), then 15 (out_last=1) on consecutive cycles; done pulses one cycle after; load_ready returns to 1.
- Load 32'hFFFF_FFFF with out_ready=1 -> addresses 0..31 in 32 consecutive cycles; out_last only with 31; pending ends at 0.
- Load 32'h8000_0004 and hold out_ready=0 for 5 cycles -> out_address stays 2 and pending stays 32'h8000_0004; release -> 2, then 31, then done.
- Load 32'h0 -> no out_valid; done pulses next cycle; state stays IDLE.
- Load 32'h0000_00F0 and assert reset mid-drain after address 4 is accepted -> immediately out_valid=0, pending=0, load_ready=1; no addresses 5..7 emitted.
- Present load_valid with 32'h1 while draining 32'h0000_0300 -> ignored (load_ready=0); output 8, 9, done; the new load is accepted only in the done/IDLE cycle, then address 0 follows.
